mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the npc core.
- Replaces direct per-unit memory calls once fetch and load/store become multi-cycle.
- Accepts one request at a time, forwards it downstream with a valid/ready handshake, and routes the response back to the owner.
- A watchdog counter aborts transactions that never receive a response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (write mask is DATA_W/8 bits).
- TIMEOUT, 255, maximum WAIT cycles before abort; legal range 1..65535.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: asynchronous active-high reset.
- ifu_req_valid in 1: IFU read request.
- ifu_req_ready out 1: IFU request accepted this cycle.
- ifu_addr in ADDR_W: IFU fetch address.
- ifu_resp_valid out 1: one-cycle pulse, IFU read data valid.
- ifu_rdata out DATA_W: IFU read data.
- lsu_req_valid in 1: LSU request.
- lsu_req_ready out 1: LSU request accepted this cycle.
- lsu_addr in ADDR_W: LSU address.
- lsu_wen in 1: 1 = write, 0 = read.
- lsu_wdata in DATA_W: write data.
- lsu_wmask in DATA_W/8: byte write mask.
- lsu_resp_valid out 1: one-cycle pulse, LSU response (read data or write ack).
- lsu_rdata out DATA_W: LSU read data (0 for writes).
- mem_req_valid out 1: downstream request.
- mem_req_ready in 1: downstream accepts request.
- mem_addr out ADDR_W: latched address.
- mem_wen out 1: latched write enable.
- mem_wdata out DATA_W: latched write data.
- mem_wmask out DATA_W/8: latched write mask.
- mem_resp_valid in 1: downstream response.
- mem_rdata in DATA_W: downstream read data.
- bus_err out 1: one-cycle pulse on timeout abort.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: state = IDLE, owner = IFU, rr_last = IFU, counter = 0.
  - All outputs are 0, including ready, valid, error, address, data and mask outputs.
  - Reset mid-transaction abandons the transaction. No response pulse is issued.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Grant is combinational: LSU wins if lsu_req_valid, otherwise IFU if ifu_req_valid.
  - ifu_req_ready / lsu_req_ready are asserted only in IDLE, only for the granted unit. They are never both asserted.
  - On valid & ready, latch addr/wen/wdata/wmask (IFU forces wen = 0, wmask = 0) and owner, then go to REQ.
  - A mem_resp_valid arriving in IDLE (stale) is ignored.
- REQ:
  - mem_req_valid = 1 with latched fields, held stable until mem_req_ready.
  - On mem_req_ready, go to WAIT and clear counter.
  - REQ has no timeout.
- WAIT:
  - Counter increments each cycle.
  - On mem_resp_valid: register mem_rdata into the owner's rdata and pulse the owner's resp_valid on the next cycle. Go to IDLE.
  - LSU write: lsu_rdata = 0.
  - If counter == TIMEOUT-1 with no response: pulse owner resp_valid with rdata = 0, pulse bus_err, go to IDLE.
  - If mem_resp_valid arrives in the same cycle as the timeout, the response wins and there is no error.
- Latency:
  - Request accepted at cycle N, mem_req_valid at N+1.
  - With mem_req_ready at N+1 and mem_resp_valid at N+2, owner resp_valid is at N+3.
  - Back-to-back acceptance is possible at N+3 (FSM is in IDLE at N+3).
- rdata outputs hold their last value between pulses.
- Only one transaction is outstanding. The non-owner sees ready = 0 until IDLE.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are valid in IDLE, grant the unit that is not rr_last. rr_last updates on every acceptance. After reset, rr_last = IFU, so LSU wins the first tie.
- Undefined: fixed LSU priority as above; rr_last is not implemented.

Test Plan:
- Single IFU read: ifu_req_valid, addr 0x80000000; mem_req_ready immediate; mem_resp_valid next cycle with 0x00100073 -> ifu_resp_valid pulse with ifu_rdata = 0x00100073 at N+3. No lsu_resp_valid, bus_err = 0.
- Simultaneous requests, macro off: IFU @0x80000004 and LSU read @0x80001000 -> LSU granted first, mem_addr = 0x80001000. IFU ready only after the LSU response; second mem_addr = 0x80000004.
- Simultaneous requests repeated 4 times, ARB_ROUND_ROBIN_EN on -> grants alternate LSU, IFU, LSU, IFU.
- LSU write: wdata 0xCAFEBABE, wmask 0xF, addr 0x80002000; mem_req_ready held low 3 cycles -> mem_* stable throughout. lsu_resp_valid pulses after mem_resp_valid, lsu_rdata = 0.
- Timeout with TIMEOUT = 4: no mem_resp_valid -> after 4 WAIT cycles, owner resp_valid = 1, rdata = 0, bus_err pulse. A late mem_resp_valid in IDLE produces no output.
- Async reset asserted in WAIT -> outputs immediately 0, FSM IDLE. A subsequent request proceeds normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter: shares one memory port between IFU and LSU, with a watchdog.   |
// | Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of LSU     |
// | priority.                                                                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_W-1:0]     ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  bus_err
);

  localparam int          MASK_W   = DATA_W / 8;
  localparam logic        OWN_IFU  = 1'b0;
  localparam logic        OWN_LSU  = 1'b1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                ifu_resp_q, ifu_resp_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic                lsu_resp_q, lsu_resp_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                bus_err_q, bus_err_d;
  logic                grant_ifu, grant_lsu;

`ifdef ARB_ROUND_ROBIN_EN
  logic                rr_last_q, rr_last_d;
`endif

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == S_IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (lsu_req_valid && ifu_req_valid) begin
        grant_lsu = (rr_last_q == OWN_IFU);
        grant_ifu = (rr_last_q == OWN_LSU);
      end else begin
        grant_lsu = lsu_req_valid;
        grant_ifu = ifu_req_valid;
      end
`else
      grant_lsu = lsu_req_valid;
      grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif
    end
  end

  // Ready is masked while reset is held so every output reads 0 in reset.
  assign ifu_req_ready  = grant_ifu & ~rst;
  assign lsu_req_ready  = grant_lsu & ~rst;
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_resp_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_resp_valid = lsu_resp_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign bus_err        = bus_err_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    ifu_resp_d  = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_resp_d  = 1'b0;
    lsu_rdata_d = lsu_rdata_q;
    bus_err_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d   = rr_last_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_lsu) begin
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          owner_d = OWN_LSU;
          state_d = S_REQ;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d = OWN_LSU;
`endif
        end else if (grant_ifu) begin
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          owner_d = OWN_IFU;
          state_d = S_REQ;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d = OWN_IFU;
`endif
        end
      end

      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // A response in the timeout cycle takes precedence over the abort.
        if (mem_resp_valid) begin
          state_d = S_IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_resp_d  = 1'b1;
            lsu_rdata_d = wen_q ? '0 : mem_rdata;
          end else begin
            ifu_resp_d  = 1'b1;
            ifu_rdata_d = mem_rdata;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
          if (owner_q == OWN_LSU) begin
            lsu_resp_d  = 1'b1;
            lsu_rdata_d = '0;
          end else begin
            ifu_resp_d  = 1'b1;
            ifu_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IFU;
      cnt_q       <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_resp_q  <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_resp_q  <= 1'b0;
      lsu_rdata_q <= '0;
      bus_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= OWN_IFU;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ifu_resp_q  <= ifu_resp_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_resp_q  <= lsu_resp_d;
      lsu_rdata_q <= lsu_rdata_d;
      bus_err_q   <= bus_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter: directed self-checking bench for mem_arbiter (TIMEOUT = 4). |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ready"}, 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    check({tag, " resp"}, 64'({ifu_resp_valid, lsu_resp_valid, bus_err}), 64'd0);
    check({tag, " mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check({tag, " mem_fields"}, 64'({mem_addr, mem_wen, mem_wmask}), 64'd0);
    check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, " rdata"}, {ifu_rdata, lsu_rdata}, 64'd0);
  endtask

  // Called just after the acceptance edge: FSM is in REQ.
  task automatic serve(input int delay, input logic [31:0] data);
    repeat (delay) tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = data;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Single IFU read
    #1;
    check("ifu single ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd2);
    tick();
    ifu_req_valid = 1'b0;
    check("ifu single mem_req", 64'({mem_req_valid, mem_wen, mem_wmask}), 64'h20);
    check("ifu single mem_addr", 64'(mem_addr), 64'h8000_0000);
    check("ifu single REQ ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    serve(0, 32'h0010_0073);
    check("ifu single resp", 64'({ifu_resp_valid, lsu_resp_valid, bus_err}), 64'd4);
    check("ifu single rdata", 64'(ifu_rdata), 64'h0010_0073);
    tick();
    check("ifu single pulse end", 64'(ifu_resp_valid), 64'd0);
    check("ifu single rdata hold", 64'(ifu_rdata), 64'h0010_0073);

    // Simultaneous requests: LSU first, IFU waits
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b0;
    #1;
    check("sim grant1", 64'({ifu_req_ready, lsu_req_ready}), 64'd1);
    tick();
    lsu_req_valid = 1'b0;
    check("sim mem_addr1", 64'(mem_addr), 64'h8000_1000);
    check("sim ifu blocked", 64'(ifu_req_ready), 64'd0);
    serve(0, 32'h1111_2222);
    check("sim lsu resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd1);
    check("sim lsu rdata", 64'(lsu_rdata), 64'h1111_2222);
    check("sim grant2", 64'({ifu_req_ready, lsu_req_ready}), 64'd2);
    tick();
    ifu_req_valid = 1'b0;
    check("sim mem_addr2", 64'(mem_addr), 64'h8000_0004);
    serve(0, 32'h3333_4444);
    check("sim ifu rdata", 64'({ifu_resp_valid, ifu_rdata}), 64'h1_3333_4444);

    // Repeated ties
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_grant;
`ifdef ARB_ROUND_ROBIN_EN
      exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_grant = 2'b01;
`endif
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      #1;
      check($sformatf("tie grant %0d", i), 64'({ifu_req_ready, lsu_req_ready}), 64'(exp_grant));
      tick();
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      check($sformatf("tie mem_addr %0d", i), 64'(mem_addr),
            (exp_grant == 2'b01) ? 64'h8000_1000 : 64'h8000_0004);
      serve(0, 32'(i));
      check($sformatf("tie resp %0d", i), 64'({ifu_resp_valid, lsu_resp_valid}), 64'(exp_grant));
    end

    // LSU write with downstream back-pressure
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b1;
    lsu_wdata = 32'hCAFE_BABE; lsu_wmask = 4'hF;
    tick();
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr stall ctl %0d", i), 64'({mem_req_valid, mem_wen, mem_wmask}), 64'h3F);
      check($sformatf("wr stall data %0d", i), {mem_addr, mem_wdata}, 64'h8000_2000_CAFE_BABE);
      tick();
    end
    serve(0, 32'hDEAD_BEEF);
    check("wr resp", 64'({ifu_resp_valid, lsu_resp_valid, bus_err}), 64'd2);
    check("wr rdata zero", 64'(lsu_rdata), 64'd0);

    // Timeout: four WAIT cycles with no response
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("tmo wait %0d", i), 64'({ifu_resp_valid, bus_err}), 64'd0);
    end
    tick();
    check("tmo resp", 64'({ifu_resp_valid, lsu_resp_valid, bus_err}), 64'h5);
    check("tmo rdata", 64'(ifu_rdata), 64'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_resp_valid = 1'b0;
    check("stale resp", 64'({ifu_resp_valid, lsu_resp_valid, bus_err, mem_req_valid}), 64'd0);
    check("stale rdata", 64'(ifu_rdata), 64'd0);

    // Response arriving in the timeout cycle wins
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0;
    tick();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick(); tick(); tick();
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    check("edge resp", 64'({ifu_resp_valid, lsu_resp_valid, bus_err}), 64'd2);
    check("edge rdata", 64'(lsu_rdata), 64'h1234_5678);

    // Async reset while in WAIT
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all_zero("async rst");
    tick();
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h9999_9999;
    tick();
    mem_resp_valid = 1'b0;
    check("post rst no resp", 64'({ifu_resp_valid, lsu_resp_valid, bus_err}), 64'd0);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
    #1;
    check("post rst ready", 64'(ifu_req_ready), 64'd1);
    tick();
    ifu_req_valid = 1'b0;
    check("post rst mem_addr", 64'(mem_addr), 64'h8000_0300);
    serve(1, 32'h0BAD_F00D);
    check("post rst resp", 64'({ifu_resp_valid, ifu_rdata}), 64'h1_0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
